// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES state-layout types, constants and ShiftRows permutation
package aes_pkg;

    localparam int NB     = 4;
    localparam int NBYTES = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_SHIFT,
        ST_DONE
    } aes_state_t;

    typedef struct packed {
        logic [1:0] col;
        logic [1:0] row;
    } byte_pos_t;

    // Byte k of the state is column k/4, row k%4 (column-major, row 0 in the MSB).
    function automatic byte_pos_t byte_pos(input logic [3:0] k);
        byte_pos_t p;
        p.col = k[3:2];
        p.row = k[1:0];
        return p;
    endfunction

    // Row r rotates left by r columns (right by r when inverse is set).
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inverse);
        logic [127:0] o;
        logic [1:0]   src;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inverse ? 2'(c - r) : 2'(c + r);
                o[127 - 32*c - 8*r -: 8] = s[127 - 32*int'(src) - 8*r -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward/inverse S-box
module aes_sbox #(
    parameter bit INVERSE = 1'b0
) (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 in GF(2^8); maps 0 to 0 as AES requires.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] y);
        return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
    endfunction

    generate
        if (INVERSE) begin : g_inv
            assign dout = ginv(inv_affine(din));
        end else begin : g_fwd
            assign dout = affine(ginv(din));
        end
    endgenerate

endmodule

// File: rtl/subbytes_shiftrows_module.sv
// rtl/subbytes_shiftrows_module.sv - iterative SubBytes + ShiftRows round stage
module subbytes_shiftrows_module
    import aes_pkg::*;
#(
    parameter int LANES   = 1,
    parameter bit INVERSE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] statew1,
    input  logic [31:0] statew2,
    input  logic [31:0] statew3,
    input  logic [31:0] statew4,
    output logic        done,
    output logic [31:0] new_statew1,
    output logic [31:0] new_statew2,
    output logic [31:0] new_statew3,
    output logic [31:0] new_statew4
);

    localparam int STEPS = NBYTES / LANES;
    localparam int LG    = (LANES == 4) ? 2 : (LANES == 2) ? 1 : 0;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("subbytes_shiftrows_module: LANES must be 1, 2 or 4");
        end
    endgenerate

    aes_state_t              fsm_q;
    logic [127:0]            st_q;
    logic [127:0]            st_sub;
    logic [3:0]              cnt_q;
    logic [LANES-1:0][7:0]   sb_in;
    logic [LANES-1:0][7:0]   sb_out;
    logic [6:0]              lane_lsb [LANES];

    always_comb begin
        byte_pos_t pos;
        pos = '0;
        for (int j = 0; j < LANES; j++) begin
            pos         = byte_pos(4'(cnt_q << LG) + 4'(j));
            lane_lsb[j] = 7'(120 - 32*int'(pos.col) - 8*int'(pos.row));
        end
    end

    always_comb begin
        st_sub = st_q;
        sb_in  = '0;
        for (int j = 0; j < LANES; j++) begin
            sb_in[j]                = st_q[lane_lsb[j] +: 8];
            st_sub[lane_lsb[j] +: 8] = sb_out[j];
        end
    end

    generate
        for (genvar j = 0; j < LANES; j++) begin : g_lane
            aes_sbox #(.INVERSE(INVERSE)) u_sbox (
                .din  (sb_in[j]),
                .dout (sb_out[j])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_IDLE;
            st_q        <= '0;
            cnt_q       <= '0;
            done        <= 1'b0;
            new_statew1 <= '0;
            new_statew2 <= '0;
            new_statew3 <= '0;
            new_statew4 <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        st_q  <= {statew1, statew2, statew3, statew4};
                        cnt_q <= '0;
                        fsm_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    st_q  <= st_sub;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(STEPS - 1)) fsm_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    {new_statew1, new_statew2, new_statew3, new_statew4} <= shift_rows(st_q, INVERSE);
                    done  <= 1'b1;
                    fsm_q <= ST_DONE;
                end
                ST_DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        fsm_q <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subbytes_shiftrows_module.sv
// tb/tb_subbytes_shiftrows_module.sv - randomized model-checked bench over four LANES/INVERSE builds
module tb_subbytes_shiftrows_module;

    localparam logic [127:0] FIPS_IN  = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;

    int total = 0;
    int bad   = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] sw [4];
    logic        done_v [4];
    logic [31:0] nw [4][4];

    int lanes_of [4] = '{1, 2, 4, 1};
    bit inv_of   [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat_of   [4] = '{18, 10, 6, 18};

    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < 4; g++) begin : g_dut
            localparam int L   = (g == 1) ? 2 : (g == 2) ? 4 : 1;
            localparam bit INV = (g == 3);
            subbytes_shiftrows_module #(.LANES(L), .INVERSE(INV)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .start       (start),
                .statew1     (sw[0]),
                .statew2     (sw[1]),
                .statew3     (sw[2]),
                .statew4     (sw[3]),
                .done        (done_v[g]),
                .new_statew1 (nw[g][0]),
                .new_statew2 (nw[g][1]),
                .new_statew3 (nw[g][2]),
                .new_statew4 (nw[g][3])
            );
        end
    endgenerate

    function automatic logic [127:0] dut_out(input int i);
        return {nw[i][0], nw[i][1], nw[i][2], nw[i][3]};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // S-box built by walking the multiplicative group with generator 3.
    function automatic void build_tables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
        for (int k = 0; k < 256; k++) isbox[sbox[k]] = 8'(k);
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input bit inv);
        logic [7:0]   b [16];
        logic [127:0] o;
        int           src;
        for (int k = 0; k < 16; k++)
            b[k] = inv ? isbox[s[127 - 8*k -: 8]] : sbox[s[127 - 8*k -: 8]];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? (c - r + 4) % 4 : (c + r) % 4;
                o[127 - 32*c - 8*r -: 8] = b[4*src + r];
            end
        end
        return o;
    endfunction

    // Timeline model: edges remaining until the result lands, then hold done until start drops.
    int           rem      [4] = '{0, 0, 0, 0};
    bit           in_done  [4] = '{0, 0, 0, 0};
    bit           exp_done [4] = '{0, 0, 0, 0};
    logic [127:0] lat_in   [4] = '{default: '0};
    logic [127:0] exp_out  [4] = '{default: '0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                rem[i] = 0; in_done[i] = 0; exp_done[i] = 0; exp_out[i] = '0;
            end else if (in_done[i]) begin
                if (!start) begin in_done[i] = 0; exp_done[i] = 0; end
            end else if (rem[i] > 0) begin
                rem[i]--;
                if (rem[i] == 0) begin
                    exp_out[i] = ref_round(lat_in[i], inv_of[i]);
                    exp_done[i] = 1; in_done[i] = 1;
                end
            end else if (start) begin
                lat_in[i] = {sw[0], sw[1], sw[2], sw[3]};
                rem[i] = 16 / lanes_of[i] + 1;
            end
        end
    end

    always @(posedge clk) begin
        #3;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("done[%0d]", i), 128'(done_v[i]), 128'(exp_done[i]));
            chk($sformatf("new_state[%0d]", i), dut_out(i), exp_out[i]);
        end
    end

    task automatic set_in(input logic [127:0] v);
        sw[0] = v[127:96]; sw[1] = v[95:64]; sw[2] = v[63:32]; sw[3] = v[31:0];
    endtask

    // Edge 1 is the edge that samples start; first_done holds the edge where done was first seen.
    task automatic run(input logic [127:0] v, input int hold, input bit toggle);
        int  first_done [4];
        bit  all_seen, any_done, finished;
        first_done = '{0, 0, 0, 0};
        finished = 0;
        @(negedge clk);
        set_in(v);
        start = 1'b1;
        for (int e = 1; e <= 90 && !finished; e++) begin
            @(posedge clk);
            #4;
            all_seen = 1; any_done = 0;
            for (int i = 0; i < 4; i++) begin
                if (done_v[i] && first_done[i] == 0) first_done[i] = e;
                if (first_done[i] == 0) all_seen = 0;
                if (done_v[i]) any_done = 1;
            end
            if (e >= hold) start = 1'b0;
            if (toggle && e < 18) set_in({$urandom, $urandom, $urandom, $urandom});
            if (all_seen && !any_done && e > hold) finished = 1;
        end
        if (!finished) begin
            bad++; total++;
            $display("FAIL run_timeout: done sequence never completed (hold=%0d)", hold);
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("latency[%0d]", i), 128'(first_done[i]), 128'(lat_of[i]));
    endtask

    initial begin
        build_tables();
        set_in('0);
        chk("model_sbox_00", 128'(sbox[8'h00]), 128'h63);
        chk("model_sbox_01", 128'(sbox[8'h01]), 128'h7c);
        chk("model_sbox_53", 128'(sbox[8'h53]), 128'hed);
        chk("model_isbox_63", 128'(isbox[8'h63]), 128'h00);
        chk("model_fips_fwd", ref_round(FIPS_IN, 1'b0), FIPS_OUT);
        chk("model_fips_inv", ref_round(FIPS_OUT, 1'b1), FIPS_IN);

        repeat (2) @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_done[%0d]", i), 128'(done_v[i]), 128'h0);
            chk($sformatf("reset_out[%0d]", i), dut_out(i), 128'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        run(FIPS_IN, 1, 1'b0);
        chk("fips_lanes1", dut_out(0), FIPS_OUT);

        run({4{32'h00000001}}, 30, 1'b0);
        chk("ones_lanes1", dut_out(0), {4{32'h6363637c}});

        run('0, 1, 1'b0);
        chk("zero_lanes2", dut_out(1), {4{32'h63636363}});
        chk("zero_lanes4", dut_out(2), {4{32'h63636363}});

        run(FIPS_OUT, 1, 1'b0);
        chk("inv_fips", dut_out(3), FIPS_IN);
        run({4{32'h63636363}}, 2, 1'b0);
        chk("inv_all63", dut_out(3), 128'h0);

        // Abort with the LANES=1 build mid-SUB (counter 7 after edge 8).
        run(FIPS_IN, 1, 1'b0);
        @(negedge clk);
        set_in({4{32'hdeadbeef}});
        start = 1'b1;
        repeat (8) @(posedge clk);
        #4;
        rst = 1'b1;
        #1;
        chk("abort_done", 128'(done_v[0]), 128'h0);
        chk("abort_out", dut_out(0), 128'h0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run(FIPS_IN, 1, 1'b0);
        chk("after_abort", dut_out(0), FIPS_OUT);

        run(FIPS_IN, 3, 1'b1);
        chk("toggle_inputs", dut_out(0), FIPS_OUT);

        for (int n = 0; n < 8; n++)
            run({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 24), 1'($urandom_range(0, 1)));

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
